// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
// Module      : rom_loader
// Description : Boot-image loader sitting in front of the instruction ROM
//               write port. It takes a byte stream over a valid/ready
//               handshake and parses frames of the form
//                   0xA5, LEN[7:0], LEN[15:8], LEN*4 data bytes, CSUM
//               Each group of four data bytes (LSB first) is written to the
//               ROM as one 32-bit word. An 8-bit additive checksum over the
//               data bytes is verified. The core is held in reset while a
//               load is in progress and after a failed load.
// Ports       :
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   i_load_req   one-cycle pulse; starts a load from IDLE, DONE or ERR
//   i_rx_valid   byte available
//   i_rx_data    byte value
//   o_rx_ready   loader accepts a byte this cycle
//   o_wen        ROM write enable, one-cycle pulse per word
//   o_w_addr     ROM byte address
//   o_w_data     ROM write data
//   o_core_rstn  active-low reset to the core (registered)
//   o_busy       load in progress
//   o_done       last load completed with a good checksum
//   o_err        last load failed
// Revision    : 1.0 - initial release
// ============================================================================
module rom_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MEM_NUM   = 4096,
    parameter int          TIMEOUT   = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load_req,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        o_rx_ready,
    output logic        o_wen,
    output logic [31:0] o_w_addr,
    output logic [31:0] o_w_data,
    output logic        o_core_rstn,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [7:0]  c_MAGIC   = 8'hA5;
    localparam logic [31:0] c_MEM_NUM = 32'(MEM_NUM);
    localparam int          c_TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Timer value at which one more idle cycle hits the limit.
    localparam logic [c_TW-1:0] c_TLIM = c_TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MAGIC = 3'd1,
        S_LEN0  = 3'd2,
        S_LEN1  = 3'd3,
        S_DATA  = 3'd4,
        S_CSUM  = 3'd5,
        S_DONE  = 3'd6,
        S_ERR   = 3'd7
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [15:0]     r_len;
    logic [15:0]     r_word_idx;
    logic [1:0]      r_byte_idx;
    logic [7:0]      r_csum;
    logic [31:0]     r_asm;
    logic [c_TW-1:0] r_timer;
    logic            r_wen;
    logic [31:0]     r_w_addr;
    logic [31:0]     r_w_data;
    logic            r_core_rstn;
    logic            r_done;
    logic            r_err;

    logic            w_busy;
    logic            w_hs;
    logic            w_timeout;
    logic            w_enter_magic;
    logic [15:0]     w_len;
    logic            w_last_byte;
    logic            w_last_word;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next        = r_state;
        w_busy        = 1'b0;
        w_enter_magic = 1'b0;
        w_len         = {i_rx_data, r_len[7:0]};
        w_last_byte   = (r_byte_idx == 2'd3);
        w_last_word   = (r_word_idx == (r_len - 16'd1));

        case (r_state)
            S_MAGIC, S_LEN0, S_LEN1, S_DATA, S_CSUM: w_busy = 1'b1;
            default:                                 w_busy = 1'b0;
        endcase

        w_hs      = i_rx_valid & w_busy;
        w_timeout = w_busy & ~w_hs & (r_timer == c_TLIM);

        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_load_req) begin
                    w_next        = S_MAGIC;
                    w_enter_magic = 1'b1;
                end
            end
            S_MAGIC: begin
                // Anything other than the magic byte is dropped to resync.
                if (w_hs && (i_rx_data == c_MAGIC)) w_next = S_LEN0;
            end
            S_LEN0: begin
                if (w_hs) w_next = S_LEN1;
            end
            S_LEN1: begin
                if (w_hs) begin
                    if (32'(w_len) > c_MEM_NUM) w_next = S_ERR;
                    else if (w_len == 16'd0)    w_next = S_CSUM;
                    else                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_hs && w_last_byte && w_last_word) w_next = S_CSUM;
            end
            S_CSUM: begin
                if (w_hs) w_next = (i_rx_data == r_csum) ? S_DONE : S_ERR;
            end
            default: w_next = S_IDLE;
        endcase

        // A timeout can only fire in a cycle without a handshake, so it
        // never overrides a byte transition.
        if (w_timeout) w_next = S_ERR;
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_word_idx  <= '0;
            r_byte_idx  <= '0;
            r_csum      <= '0;
            r_asm       <= '0;
            r_timer     <= '0;
            r_wen       <= 1'b0;
            r_w_addr    <= '0;
            r_w_data    <= '0;
            r_core_rstn <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wen <= 1'b0;

            if (w_enter_magic) begin
                r_word_idx <= '0;
                r_byte_idx <= '0;
                r_csum     <= '0;
                r_timer    <= '0;
            end else if (w_busy) begin
                r_timer <= w_hs ? '0 : (r_timer + 1'b1);
            end

            if (w_hs) begin
                case (r_state)
                    S_LEN0: r_len[7:0]  <= i_rx_data;
                    S_LEN1: r_len[15:8] <= i_rx_data;
                    S_DATA: begin
                        r_asm      <= {i_rx_data, r_asm[31:8]};
                        r_csum     <= r_csum + i_rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_last_byte) begin
                            // Word is complete with this byte; issue the
                            // write in the following cycle.
                            r_wen      <= 1'b1;
                            r_w_data   <= {i_rx_data, r_asm[31:8]};
                            r_w_addr   <= BASE_ADDR + {14'd0, r_word_idx, 2'b00};
                            r_word_idx <= r_word_idx + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end

            // Status follows the state being entered so it lines up with it.
            r_core_rstn <= (w_next == S_IDLE) || (w_next == S_DONE);
            r_done      <= (w_next == S_DONE);
            r_err       <= (w_next == S_ERR);
        end
    end

    assign o_rx_ready  = w_busy;
    assign o_busy      = w_busy;
    assign o_wen       = r_wen;
    assign o_w_addr    = r_w_addr;
    assign o_w_data    = r_w_data;
    assign o_core_rstn = r_core_rstn;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule
`default_nettype wire
